// File: rtl/fp_multiplier.sv
// Sequential IEEE-754 single-precision multiplier with an iterative shift-add mantissa datapath.
// Define FP_MUL_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_multiplier #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] Number1,
  input  logic [31:0] Number2,
  input  logic        result_ack,
  output logic [31:0] Result,
  output logic        result_ready,
  output logic        busy
);

  localparam int K = 24 / BITS_PER_CYCLE;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q,  state_d;
  logic [31:0]        op_a_q,   op_a_d;
  logic [31:0]        op_b_q,   op_b_d;
  logic               sign_q,   sign_d;
  logic signed [9:0]  exp_q,    exp_d;
  logic               nan_q,    nan_d;
  logic               inf_q,    inf_d;
  logic               zero_q,   zero_d;
  logic [47:0]        mcand_q,  mcand_d;
  logic [23:0]        mplier_q, mplier_d;
  logic [47:0]        acc_q,    acc_d;
  logic [4:0]         cnt_q,    cnt_d;
  logic [31:0]        result_q, result_d;
  logic               ready_q,  ready_d;
  logic               busy_q,   busy_d;

  logic [47:0]        pp_s;
  logic [22:0]        mant_s;
  logic signed [9:0]  norm_exp_s;
  logic [31:0]        prod_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s;

  assign Result       = result_q;
  assign result_ready = ready_q;
  assign busy         = busy_q;

  assign a_zero_s = (op_a_q[30:23] == 8'h00);
  assign b_zero_s = (op_b_q[30:23] == 8'h00);
  assign a_inf_s  = (op_a_q[30:23] == 8'hFF);
  assign b_inf_s  = (op_b_q[30:23] == 8'hFF);

  // Partial products for the BITS_PER_CYCLE low multiplier bits of this iteration.
  always_comb begin
    pp_s = 48'h0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) begin
        pp_s = pp_s + (mcand_q << j);
      end else begin
        pp_s = pp_s;
      end
    end
  end

`ifdef FP_MUL_RNE_EN
  logic        guard_s;
  logic        sticky_s;
  logic        round_up_s;
  logic [23:0] rounded_s;

  // Normalise, then round to nearest even; a carry-out bumps the exponent.
  always_comb begin
    if (acc_q[47]) begin
      mant_s     = acc_q[46:24];
      guard_s    = acc_q[23];
      sticky_s   = |acc_q[22:0];
      norm_exp_s = exp_q + 10'sd1;
    end else begin
      mant_s     = acc_q[45:23];
      guard_s    = acc_q[22];
      sticky_s   = |acc_q[21:0];
      norm_exp_s = exp_q;
    end
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    rounded_s  = {1'b0, mant_s} + {23'h0, round_up_s};
    if (rounded_s[23]) begin
      norm_exp_s = norm_exp_s + 10'sd1;
    end else begin
      norm_exp_s = norm_exp_s;
    end
    mant_s = rounded_s[22:0];
  end
`else
  logic unused_lsb_s;
  assign unused_lsb_s = ^acc_q[22:0];

  // Normalise with truncation toward zero.
  always_comb begin
    if (acc_q[47]) begin
      mant_s     = acc_q[46:24];
      norm_exp_s = exp_q + 10'sd1;
    end else begin
      mant_s     = acc_q[45:23];
      norm_exp_s = exp_q;
    end
  end
`endif

  // Special operands take priority over the range checks on the computed exponent.
  always_comb begin
    if (nan_q) begin
      prod_s = 32'h7FC0_0000;
    end else if (inf_q) begin
      prod_s = {sign_q, 8'hFF, 23'h0};
    end else if (zero_q) begin
      prod_s = {sign_q, 31'h0};
    end else if (norm_exp_s >= 10'sd255) begin
      prod_s = {sign_q, 8'hFF, 23'h0};
    end else if (norm_exp_s <= 10'sd0) begin
      prod_s = {sign_q, 31'h0};
    end else begin
      prod_s = {sign_q, norm_exp_s[7:0], mant_s};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          op_a_d  = Number1;
          op_b_d  = Number2;
          state_d = S_UNPACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UNPACK: begin
        sign_d   = op_a_q[31] ^ op_b_q[31];
        exp_d    = $signed({2'b00, op_a_q[30:23]}) + $signed({2'b00, op_b_q[30:23]}) - 10'sd127;
        nan_d    = (a_inf_s & b_zero_s) | (b_inf_s & a_zero_s);
        inf_d    = a_inf_s | b_inf_s;
        zero_d   = a_zero_s | b_zero_s;
        mcand_d  = {24'h0, ~a_zero_s, op_a_q[22:0]};
        mplier_d = {~b_zero_s, op_b_q[22:0]};
        acc_d    = 48'h0;
        cnt_d    = 5'd0;
        state_d  = S_MULT;
      end
      S_MULT: begin
        acc_d    = acc_q + pp_s;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'(K - 1)) begin
          state_d = S_NORM;
        end else begin
          state_d = S_MULT;
        end
      end
      S_NORM: begin
        result_d = prod_s;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (result_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_a_q   <= 32'h0;
      op_b_q   <= 32'h0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= 48'h0;
      mplier_q <= 24'h0;
      acc_q    <= 48'h0;
      cnt_q    <= 5'd0;
      result_q <= 32'h0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench for fp_multiplier: directed cases, handshake corners, mid-run reset
// and random operands checked against an arithmetic reference model.
module tb_fp_multiplier;

  localparam int BPC = 1;
  localparam int K   = 24 / BPC;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] Number1;
  logic [31:0] Number2;
  logic        result_ack;
  logic [31:0] Result;
  logic        result_ready;
  logic        busy;

  int checks;
  int errors;

  fp_multiplier #(.BITS_PER_CYCLE(BPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .Number1      (Number1),
    .Number2      (Number2),
    .result_ack   (result_ack),
    .Result       (Result),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued significand product, normalised and rounded by comparing the remainder with one half ulp.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              ea, eb, e, sh;
    longint unsigned ma, mb, p, mant;
`ifdef FP_MUL_RNE_EN
    longint unsigned rem, half;
`endif
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= 64'h0000_8000_0000_0000) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    mant = (p >> sh) & 64'h7F_FFFF;
`ifdef FP_MUL_RNE_EN
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) begin
      mant = mant + 64'd1;
      if (mant == 64'h80_0000) begin
        mant = 64'd0;
        e    = e + 1;
      end
    end
`endif
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  // Launch one operation, optionally pulsing a stray load during MULT, and wait for result_ready.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input string tag, input bit mid_load);
    int n;
    @(negedge clk);
    Number1 = a;
    Number2 = b;
    load    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk({tag, "_busy_start"}, {31'h0, busy}, 32'd1);
    n = 0;
    while (result_ready !== 1'b1 && n < 200) begin
      if (mid_load && n == 6) begin
        load    = 1'b1;
        Number1 = 32'h3F80_0000;
        Number2 = 32'h3F80_0000;
      end else begin
        load = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    chk({tag, "_latency"}, n, K + 2);
    chk({tag, "_result"}, Result, exp);
    chk({tag, "_busy_done"}, {31'h0, busy}, 32'd1);
  endtask

  task automatic do_ack(input logic [31:0] exp, input string tag);
    result_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ack = 1'b0;
    chk({tag, "_ready_after_ack"}, {31'h0, result_ready}, 32'd0);
    chk({tag, "_busy_after_ack"}, {31'h0, busy}, 32'd0);
    chk({tag, "_result_kept"}, Result, exp);
  endtask

  initial begin
    logic [31:0] a, b, e;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    load       = 1'b0;
    result_ack = 1'b0;
    Number1    = 32'h0;
    Number2    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_result", Result, 32'h0);
    chk("reset_ready", {31'h0, result_ready}, 32'd0);
    chk("reset_busy", {31'h0, busy}, 32'd0);

    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "two_x_three", 1'b0);
    do_ack(32'h40C0_0000, "two_x_three");
    run_op(32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, "neg_2p25", 1'b0);
    do_ack(32'hC010_0000, "neg_2p25");
    run_op(32'h8000_0000, 32'h42F6_0000, 32'h8000_0000, "neg_zero", 1'b0);
    do_ack(32'h8000_0000, "neg_zero");
    run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, "overflow", 1'b0);
    do_ack(32'h7F80_0000, "overflow");
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf_x_zero", 1'b0);
    do_ack(32'h7FC0_0000, "inf_x_zero");
    run_op(32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, "denormal", 1'b0);
    do_ack(32'h0000_0000, "denormal");
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "neg_inf", 1'b0);
    do_ack(32'hFF80_0000, "neg_inf");
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, "underflow", 1'b0);
    do_ack(32'h0000_0000, "underflow");
`ifdef FP_MUL_RNE_EN
    e = 32'h3FC0_0002;
`else
    e = 32'h3FC0_0001;
`endif
    run_op(32'h3F80_0001, 32'h3FC0_0000, e, "rounding", 1'b0);
    do_ack(e, "rounding");

    // Stray load in MULT, then a long wait and another stray load in DONE.
    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "mid_load", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_ready", {31'h0, result_ready}, 32'd1);
      chk("hold_result", Result, 32'h40C0_0000);
    end
    Number1 = 32'h4100_0000;
    Number2 = 32'h4100_0000;
    load    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    chk("done_load_ready", {31'h0, result_ready}, 32'd1);
    chk("done_load_result", Result, 32'h40C0_0000);
    load       = 1'b1;
    result_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load       = 1'b0;
    result_ack = 1'b0;
    chk("load_ack_ready", {31'h0, result_ready}, 32'd0);
    chk("load_ack_busy", {31'h0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("load_ack_no_capture", {31'h0, busy}, 32'd0);

    // Reset around MULT iteration 10.
    Number1 = 32'h4000_0000;
    Number2 = 32'h4040_0000;
    load    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset_ready", {31'h0, result_ready}, 32'd0);
    chk("mid_reset_result", Result, 32'h0);
    chk("mid_reset_busy", {31'h0, busy}, 32'd0);
    run_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, "after_reset", 1'b0);
    do_ack(32'h4040_0000, "after_reset");

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 != 0) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      e = ref_mul(a, b);
      run_op(a, b, e, $sformatf("rand%0d", i), 1'b0);
      do_ack(e, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
